// File: rtl/regs_wb_ctrl_pkg.sv
// Shared core definitions: register file geometry and the write-port
// controller state encoding.
package core_defs;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    WBC_IDLE = 2'd0,
    WBC_BUSY = 2'd1,
    WBC_HOLD = 2'd2
  } wbc_state_t;

endpackage

// File: rtl/regs_wb_ctrl_if.sv
// Bundle of the ID, WB, divider and register file port signals seen by the
// write-port controller.
interface regs_wb_ctrl_if;
  import core_defs::*;

  logic [REG_ADDR_W-1:0] id_rs1_i;
  logic [REG_ADDR_W-1:0] id_rs2_i;
  logic [REG_ADDR_W-1:0] id_rd_i;
  logic                  id_rd_we_i;
  logic                  id_div_i;
  logic                  id_fire_i;
  logic                  id_stall_o;

  logic                  wb_wen_i;
  logic [REG_ADDR_W-1:0] wb_waddr_i;
  logic [XLEN-1:0]       wb_wdata_i;
  logic                  wb_stall_o;

  logic                  div_valid_i;
  logic [XLEN-1:0]       div_data_i;
  logic                  div_ready_o;

  logic [REG_ADDR_W-1:0] reg_waddr_o;
  logic [XLEN-1:0]       reg_wdata_o;
  logic                  reg_wen_o;

  modport slave (
    input  id_rs1_i, id_rs2_i, id_rd_i, id_rd_we_i, id_div_i, id_fire_i,
    input  wb_wen_i, wb_waddr_i, wb_wdata_i,
    input  div_valid_i, div_data_i,
    output id_stall_o, wb_stall_o, div_ready_o,
    output reg_waddr_o, reg_wdata_o, reg_wen_o
  );

  modport master (
    output id_rs1_i, id_rs2_i, id_rd_i, id_rd_we_i, id_div_i, id_fire_i,
    output wb_wen_i, wb_waddr_i, wb_wdata_i,
    output div_valid_i, div_data_i,
    input  id_stall_o, wb_stall_o, div_ready_o,
    input  reg_waddr_o, reg_wdata_o, reg_wen_o
  );

endinterface

// File: rtl/regs_wb_ctrl_scoreboard.sv
// Busy-bit scoreboard for the register file: one bit per register, set on
// divide issue, cleared on divide commit, with three hazard lookups.
module reg_scoreboard
  import core_defs::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] rd,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rd_busy
);

  logic [31:0] busy;

  // x0 is never marked busy, so lookups on x0 always read clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_addr] <= 1'b0;
      if (set_en && (set_addr != REG_ZERO)) busy[set_addr] <= 1'b1;
    end
  end

  assign rs1_busy = busy[rs1];
  assign rs2_busy = busy[rs2];
  assign rd_busy  = busy[rd];

endmodule

// File: rtl/regs_wb_ctrl.sv
// Register file write-port controller: arbitrates WB against one outstanding
// divide result and raises ID hazard stalls against the divide destination.
module regs_wb_ctrl
  import core_defs::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input logic           clk,
  input logic           rst,
  regs_wb_ctrl_if.slave bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  wbc_state_t            state;
  logic [REG_ADDR_W-1:0] div_rd;
  logic [XLEN-1:0]       hold;
  logic [3:0]            starve;

  logic wb_ok, starved, commit, issue, track;
  logic rs1_busy, rs2_busy, rd_busy;
  logic                  wen;
  logic [REG_ADDR_W-1:0] waddr;
  logic [XLEN-1:0]       wdata;
  logic                  stall;

  assign wb_ok   = bus.wb_wen_i && (bus.wb_waddr_i != REG_ZERO);
  assign starved = (state == WBC_HOLD) && (starve == STARVE_LIM);
  assign commit  = (state == WBC_HOLD) && (starved || !wb_ok);
  assign track   = bus.id_rd_we_i && (bus.id_rd_i != REG_ZERO);
  assign issue   = (state == WBC_IDLE) && bus.id_fire_i && bus.id_div_i;

  reg_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue && track),
    .set_addr (bus.id_rd_i),
    .clr_en   (commit),
    .clr_addr (div_rd),
    .rs1      (bus.id_rs1_i),
    .rs2      (bus.id_rs2_i),
    .rd       (bus.id_rd_i),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy)
  );

  // Untracked divides (rd=x0 or no writeback) still go through BUSY so the
  // divider's result is accepted, then it is dropped instead of entering HOLD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= WBC_IDLE;
      div_rd <= '0;
      hold   <= '0;
      starve <= '0;
    end else begin
      case (state)
        WBC_IDLE: begin
          if (issue) begin
            div_rd <= track ? bus.id_rd_i : REG_ZERO;
            state  <= WBC_BUSY;
          end
        end
        WBC_BUSY: begin
          if (bus.div_valid_i) begin
            if (div_rd == REG_ZERO) begin
              state <= WBC_IDLE;
            end else begin
              hold  <= bus.div_data_i;
              state <= WBC_HOLD;
            end
          end
        end
        WBC_HOLD: begin
          if (commit) begin
            starve <= '0;
            state  <= WBC_IDLE;
          end else begin
            starve <= starve + 4'd1;
          end
        end
        default: state <= WBC_IDLE;
      endcase
    end
  end

  always_comb begin
    wen   = 1'b0;
    waddr = '0;
    wdata = '0;
    if (starved) begin
      wen   = 1'b1;
      waddr = div_rd;
      wdata = hold;
    end else if (wb_ok) begin
      wen   = 1'b1;
      waddr = bus.wb_waddr_i;
      wdata = bus.wb_wdata_i;
    end else if (state == WBC_HOLD) begin
      wen   = 1'b1;
      waddr = div_rd;
      wdata = hold;
    end
  end

  assign stall = ((bus.id_rs1_i != REG_ZERO) && rs1_busy) ||
                 ((bus.id_rs2_i != REG_ZERO) && rs2_busy) ||
                 (bus.id_rd_we_i && (bus.id_rd_i != REG_ZERO) && rd_busy) ||
                 (bus.id_div_i && (state != WBC_IDLE));

  // Outputs are gated by reset so a live WB write cannot leak while rst is low.
  assign bus.reg_wen_o   = rst && wen;
  assign bus.reg_waddr_o = rst ? waddr : '0;
  assign bus.reg_wdata_o = rst ? wdata : '0;
  assign bus.id_stall_o  = rst && stall;
  assign bus.wb_stall_o  = rst && starved;
  assign bus.div_ready_o = rst && (state == WBC_BUSY);

endmodule
